pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline controller for the 5-stage core (Q100H fetch, Q101H decode, Q102H execute, Q103H memory, Q104H write-back). It tracks per-stage valid, destination register and write enable, and drives the Q102H forwarding selects that feed `t_exe_ctrl`. It also drives the stall and flush strobes that sequence the pipeline registers through load-use hazards, taken branches and data-memory wait states.

## Interface
Parameters:
- MEM_TIMEOUT, 64: consecutive wait cycles before `mem_timeout` is raised (≥2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- inst_valid_Q101H  in  1  decode holds a real instruction
- rs1_Q101H, rs2_Q101H  in  5 each  source register addresses
- rs1_used_Q101H, rs2_used_Q101H  in  1 each  source actually read
- rd_Q101H  in  5  destination register
- reg_write_en_Q101H  in  1  instruction writes rd
- mem_rd_Q101H  in  1  instruction is a load
- mem_acc_Q101H  in  1  instruction is a load or store
- branch_taken_Q102H  in  1  execute resolved a taken branch or jump
- dmem_ready  in  1  data memory completes the Q103H access this cycle
- stall_Q100H, stall_Q101H, stall_Q102H, stall_Q103H  out  1 each  hold stage register
- flush_Q101H, flush_Q102H  out  1 each  load a bubble into stage register
- fwd_sel_rs1_Q102H, fwd_sel_rs2_Q102H  out  2 each  `t_fwd_sel`
- rd_Q103H, rd_Q104H  out  5 each  tracked destination
- reg_write_en_Q103H, reg_write_en_Q104H  out  1 each  tracked write enable, gated by valid
- valid_Q102H, valid_Q103H, valid_Q104H  out  1 each  stage valid
- mem_timeout  out  1  sticky error flag

## Operation
- Internal shift pipeline carries {valid, rs1, rs2, rs*_used, rd, reg_write_en, mem_rd, mem_acc} from Q101H to Q102H to Q103H to Q104H. A stage advances unless its stall is asserted. A flushed or bubbled stage loads valid=0, reg_write_en=0 and mem_acc=0.
- FSM `t_pipe_state`:
  - RUN → MEM_WAIT when valid_Q103H & mem_acc_Q103H & !dmem_ready.
  - MEM_WAIT → RUN on dmem_ready.
- Wait condition `w` = valid_Q103H & mem_acc_Q103H & !dmem_ready, in either state.
- Wait freeze (`w`=1): all four stalls asserted, no flushes, and Q104H loads a bubble. `branch_taken_Q102H` is ignored while frozen; the datapath holds it and it is acted on in the release cycle.
- Branch (`w`=0, branch_taken_Q102H & valid_Q102H): flush_Q101H=flush_Q102H=1 and no stalls. Branch overrides a simultaneous load-use hazard.
- Load-use (`w`=0, no branch): valid_Q102H & mem_rd_Q102H & rd_Q102H≠0 & inst_valid_Q101H, and rd_Q102H matches a used rs of Q101H. Response: stall_Q100H=stall_Q101H=1 and flush_Q102H=1, for exactly one cycle.
- Forwarding for each rs of Q102H, with rs≠0 and rs_used:
  - FWD_Q103H if reg_write_en_Q103H & rd_Q103H==rs.
  - Else FWD_Q104H if reg_write_en_Q104H & rd_Q104H==rs.
  - Else FWD_NONE. Q103H has priority over Q104H.
- Wait counter:
  - Increments each cycle `w`=1 and saturates at MEM_TIMEOUT.
  - Clears when `w`=0.
  - `mem_timeout` sets when the counter reaches MEM_TIMEOUT and clears only on reset.

## Timing
- Stall, flush and fwd_sel outputs are combinational from the registered stage state and the current inputs, with zero-cycle latency. Tracked rd, write enable and valid outputs are registered.
- Load-use costs 1 bubble. A taken branch costs 2 bubbles. A memory wait of N cycles costs N bubbles at Q104H.
- Reset (asynchronous, at any time including mid-wait):
  - State RUN and counter 0.
  - All valids 0, rd 0, write enables 0.
  - fwd_sel FWD_NONE, all stalls and flushes 0, mem_timeout 0.
- The first cycle after reset deassertion behaves as RUN with an empty pipe.
- A dmem_ready arriving in the same cycle the access enters Q103H causes no wait.

## Structure
- Shared package `pkg`:
  - `t_fwd_sel` enum: FWD_NONE=2'b00, FWD_Q103H=2'b01, FWD_Q104H=2'b10.
  - `t_pipe_state` enum: RUN, MEM_WAIT.
  - Optional `t_hazard_ctrl` struct bundling the stall and flush outputs.
- Sub-module `fwd_match`: combinational compare of one rs against the Q103H/Q104H tracking, instantiated twice.

## Test plan
- Load x5 in Q102H, add x6,x5,x1 in Q101H → one cycle of stall_Q100H/stall_Q101H/flush_Q102H. The add then reaches Q102H with fwd_sel_rs1_Q102H=FWD_Q104H.
- add x3 followed directly by sub x4,x3,x3 → both fwd_sel=FWD_Q103H. Same rd also present in Q104H → still FWD_Q103H. rd=x0 → FWD_NONE.
- branch_taken_Q102H together with a load-use hazard → flush_Q101H=flush_Q102H=1 and no stalls. valid_Q102H=0 the next cycle.
- Store in Q103H with dmem_ready low for 3 cycles → state MEM_WAIT, all stalls high for 3 cycles, then release. Exactly 3 Q104H bubbles.
- MEM_TIMEOUT=4 with dmem_ready held low for 6 cycles → mem_timeout rises when the counter reaches 4 and stays high after release.
- rst_n asserted mid-MEM_WAIT → all outputs return to reset values immediately. Normal flow resumes after deassertion.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_pkg
//
// Shared types for the 5-stage pipeline hazard controller.
//   t_fwd_sel     : operand forwarding select for the Q102H operand muxes
//   t_pipe_state  : controller state (normal flow or data-memory wait)
//   t_hazard_ctrl : bundle of the stall and flush strobes
//   t_exe_stage   : instruction tracking fields held in the Q102H slot
//   rs_hit        : helper comparing a used source register to a destination
// ---------------------------------------------------------------------------
package pipe_hazard_ctrl_pkg;

  // Forwarding source for one execute operand. Q103H has priority over Q104H.
  typedef enum logic [1:0] {
    FWD_NONE  = 2'b00,
    FWD_Q103H = 2'b01,
    FWD_Q104H = 2'b10
  } t_fwd_sel;

  // RUN is normal flow; MEM_WAIT marks a data-memory access still pending.
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } t_pipe_state;

  // All pipeline sequencing strobes driven by the controller.
  typedef struct packed {
    logic stall_q100;
    logic stall_q101;
    logic stall_q102;
    logic stall_q103;
    logic flush_q101;
    logic flush_q102;
  } t_hazard_ctrl;

  // Everything the controller needs to remember about the instruction in Q102H.
  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] rd;
    logic       reg_write_en;
    logic       mem_rd;
    logic       mem_acc;
  } t_exe_stage;

  // A bubble is an all-zero slot: invalid, writes nothing, touches no memory,
  // and reads only x0 so it can never produce a forwarding or hazard match.
  localparam t_exe_stage EXE_BUBBLE = '0;

  // True when a source register is really read, is not x0 and equals rd.
  // x0 is hardwired to zero, so it never needs forwarding or interlocking.
  function automatic logic rs_hit(input logic [4:0] rs,
                                  input logic       used,
                                  input logic [4:0] rd);
    return used && (rs != 5'd0) && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_match.sv
// ---------------------------------------------------------------------------
// fwd_match
//
// Forwarding select for one execute-stage source operand. Compares the
// operand against the destinations tracked in Q103H and Q104H and picks
// the youngest producer.
//
// Ports:
//   rs       in  5  source register of the Q102H instruction
//   rs_used  in  1  the instruction really reads rs
//   rd_mem   in  5  destination tracked in Q103H
//   we_mem   in  1  Q103H writes rd_mem (already gated by valid)
//   rd_wb    in  5  destination tracked in Q104H
//   we_wb    in  1  Q104H writes rd_wb (already gated by valid)
//   sel      out 2  forwarding select (t_fwd_sel)
// ---------------------------------------------------------------------------
module fwd_match
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs,
  input  logic       rs_used,
  input  logic [4:0] rd_mem,
  input  logic       we_mem,
  input  logic [4:0] rd_wb,
  input  logic       we_wb,
  output t_fwd_sel   sel
);

  // The Q103H producer is younger than the Q104H one, so when both write the
  // same register the Q103H value is the architecturally correct one and
  // must win. With no producer match the register file value is used.
  always_comb begin
    sel = FWD_NONE;
    if (we_mem && rs_hit(rs, rs_used, rd_mem)) begin
      sel = FWD_Q103H;
    end else if (we_wb && rs_hit(rs, rs_used, rd_wb)) begin
      sel = FWD_Q104H;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and forwarding controller for the 5-stage core
// (Q100H fetch, Q101H decode, Q102H execute, Q103H memory, Q104H write-back).
// It shadows the instruction flow from Q101H onwards, detects load-use
// hazards, taken branches and data-memory wait states, and drives the stall,
// flush and execute forwarding selects that sequence the pipeline registers.
//
// Parameters:
//   MEM_TIMEOUT  consecutive wait cycles before mem_timeout is raised (>=2)
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   inst_valid_Q101H               decode holds a real instruction
//   rs1/rs2_Q101H, rs*_used_Q101H  decode source registers and their use
//   rd_Q101H, reg_write_en_Q101H   decode destination and write enable
//   mem_rd_Q101H, mem_acc_Q101H    decode instruction is a load / load-store
//   branch_taken_Q102H             execute resolved a taken branch or jump
//   dmem_ready                     data memory completes the Q103H access
//   stall_Q100H..stall_Q103H       hold the corresponding stage register
//   flush_Q101H, flush_Q102H       load a bubble into the stage register
//   fwd_sel_rs1/rs2_Q102H          execute operand forwarding selects
//   rd_Q103H/Q104H, reg_write_en_Q103H/Q104H, valid_Q102H..Q104H
//                                  registered tracking of the later stages
//   mem_timeout                    sticky data-memory timeout flag
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inst_valid_Q101H,
  input  logic [4:0] rs1_Q101H,
  input  logic [4:0] rs2_Q101H,
  input  logic       rs1_used_Q101H,
  input  logic       rs2_used_Q101H,
  input  logic [4:0] rd_Q101H,
  input  logic       reg_write_en_Q101H,
  input  logic       mem_rd_Q101H,
  input  logic       mem_acc_Q101H,
  input  logic       branch_taken_Q102H,
  input  logic       dmem_ready,
  output logic       stall_Q100H,
  output logic       stall_Q101H,
  output logic       stall_Q102H,
  output logic       stall_Q103H,
  output logic       flush_Q101H,
  output logic       flush_Q102H,
  output t_fwd_sel   fwd_sel_rs1_Q102H,
  output t_fwd_sel   fwd_sel_rs2_Q102H,
  output logic [4:0] rd_Q103H,
  output logic [4:0] rd_Q104H,
  output logic       reg_write_en_Q103H,
  output logic       reg_write_en_Q104H,
  output logic       valid_Q102H,
  output logic       valid_Q103H,
  output logic       valid_Q104H,
  output logic       mem_timeout
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  t_exe_stage       exe_q;
  t_exe_stage       dec_stage;
  logic             mem_acc_q103;
  t_hazard_ctrl     hz;
  logic             wait_mem;
  logic             branch_flush;
  logic             load_use;
  t_pipe_state      state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;

  // Decode-stage view of the incoming instruction. An empty decode slot is
  // turned into a clean bubble so that stale register addresses or enables
  // never leak into execute and trigger false forwarding or interlocks.
  always_comb begin
    dec_stage = EXE_BUBBLE;
    if (inst_valid_Q101H) begin
      dec_stage.valid        = 1'b1;
      dec_stage.rs1          = rs1_Q101H;
      dec_stage.rs2          = rs2_Q101H;
      dec_stage.rs1_used     = rs1_used_Q101H;
      dec_stage.rs2_used     = rs2_used_Q101H;
      dec_stage.rd           = rd_Q101H;
      dec_stage.reg_write_en = reg_write_en_Q101H;
      dec_stage.mem_rd       = mem_rd_Q101H;
      dec_stage.mem_acc      = mem_acc_Q101H;
    end
  end

  // Hazard conditions, all derived from registered stage state plus the
  // current-cycle inputs. A pending memory access freezes the whole pipe and
  // masks everything else; the datapath keeps the branch result in Q102H so
  // it gets acted on in the release cycle. A taken branch squashes the two
  // younger instructions, which makes any load-use hazard against them moot.
  always_comb begin
    wait_mem     = valid_Q103H && mem_acc_q103 && !dmem_ready;
    branch_flush = exe_q.valid && branch_taken_Q102H;
    load_use     = exe_q.valid && exe_q.mem_rd && (exe_q.rd != 5'd0) &&
                   inst_valid_Q101H &&
                   (rs_hit(rs1_Q101H, rs1_used_Q101H, exe_q.rd) ||
                    rs_hit(rs2_Q101H, rs2_used_Q101H, exe_q.rd));
  end

  // Strobe generation in priority order: memory freeze, branch, load-use.
  // Load-use holds fetch and decode and drops a bubble into execute; once the
  // bubble is in Q102H the hazard is gone, so the response lasts one cycle.
  always_comb begin
    hz = '0;
    if (wait_mem) begin
      hz.stall_q100 = 1'b1;
      hz.stall_q101 = 1'b1;
      hz.stall_q102 = 1'b1;
      hz.stall_q103 = 1'b1;
    end else if (branch_flush) begin
      hz.flush_q101 = 1'b1;
      hz.flush_q102 = 1'b1;
    end else if (load_use) begin
      hz.stall_q100 = 1'b1;
      hz.stall_q101 = 1'b1;
      hz.flush_q102 = 1'b1;
    end
  end

  assign stall_Q100H = hz.stall_q100;
  assign stall_Q101H = hz.stall_q101;
  assign stall_Q102H = hz.stall_q102;
  assign stall_Q103H = hz.stall_q103;
  assign flush_Q101H = hz.flush_q101;
  assign flush_Q102H = hz.flush_q102;
  assign valid_Q102H = exe_q.valid;

  // Q102H tracking slot. It holds while stalled, takes a bubble on a flush,
  // and otherwise captures whatever decode presents this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_q <= EXE_BUBBLE;
    end else if (!hz.stall_q102) begin
      exe_q <= hz.flush_q102 ? EXE_BUBBLE : dec_stage;
    end
  end

  // Q103H tracking. Only the fields later stages and the wait detector need
  // are kept. The write enable is stored already gated by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_Q103H        <= 1'b0;
      rd_Q103H           <= 5'd0;
      reg_write_en_Q103H <= 1'b0;
      mem_acc_q103       <= 1'b0;
    end else if (!hz.stall_q103) begin
      valid_Q103H        <= exe_q.valid;
      rd_Q103H           <= exe_q.rd;
      reg_write_en_Q103H <= exe_q.valid && exe_q.reg_write_en;
      mem_acc_q103       <= exe_q.valid && exe_q.mem_acc;
    end
  end

  // Q104H tracking. While memory is pending the access stays in Q103H and a
  // bubble drains into write-back, one per wait cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_Q104H        <= 1'b0;
      rd_Q104H           <= 5'd0;
      reg_write_en_Q104H <= 1'b0;
    end else if (wait_mem) begin
      valid_Q104H        <= 1'b0;
      rd_Q104H           <= 5'd0;
      reg_write_en_Q104H <= 1'b0;
    end else begin
      valid_Q104H        <= valid_Q103H;
      rd_Q104H           <= rd_Q103H;
      reg_write_en_Q104H <= valid_Q103H && reg_write_en_Q103H;
    end
  end

  // Controller state: enter MEM_WAIT when an access in Q103H is not
  // completed, leave it on the cycle memory reports ready. The freeze itself
  // follows the wait condition directly, so the state mainly documents the
  // pipe's phase for debug visibility.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:      if (wait_mem)   state <= MEM_WAIT;
        MEM_WAIT: if (dmem_ready) state <= RUN;
        default:                  state <= RUN;
      endcase
    end
  end

  // Consecutive wait cycles, saturating so it can never wrap back to zero
  // and hide an overlong stall.
  always_comb begin
    wait_cnt_next = '0;
    if (wait_mem) begin
      wait_cnt_next = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + CNT_W'(1);
    end
  end

  // The timeout flag rises together with the counter reaching its limit and
  // then stays set until reset, so software can see that it ever happened.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      wait_cnt    <= wait_cnt_next;
      mem_timeout <= mem_timeout || (wait_cnt_next == CNT_MAX);
    end
  end

  fwd_match u_fwd_rs1 (
    .rs      (exe_q.rs1),
    .rs_used (exe_q.rs1_used),
    .rd_mem  (rd_Q103H),
    .we_mem  (reg_write_en_Q103H),
    .rd_wb   (rd_Q104H),
    .we_wb   (reg_write_en_Q104H),
    .sel     (fwd_sel_rs1_Q102H)
  );

  fwd_match u_fwd_rs2 (
    .rs      (exe_q.rs2),
    .rs_used (exe_q.rs2_used),
    .rd_mem  (rd_Q103H),
    .we_mem  (reg_write_en_Q103H),
    .rd_wb   (rd_Q104H),
    .we_wb   (reg_write_en_Q104H),
    .sel     (fwd_sel_rs2_Q102H)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl built with MEM_TIMEOUT=4. Inputs change
// on the falling clock edge and outputs are sampled 1 ns later, well away
// from the rising edge. Expected values are hand-computed per step.
// Hazard strobe vector: {stall_Q100H, stall_Q101H, stall_Q102H, stall_Q103H,
// flush_Q101H, flush_Q102H}.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam logic [7:0] HZ_NONE   = 8'h00;
  localparam logic [7:0] HZ_LDUSE  = 8'h31;
  localparam logic [7:0] HZ_BRANCH = 8'h03;
  localparam logic [7:0] HZ_FREEZE = 8'h3C;

  logic       clk;
  logic       rst_n;
  logic       inst_valid_Q101H;
  logic [4:0] rs1_Q101H;
  logic [4:0] rs2_Q101H;
  logic       rs1_used_Q101H;
  logic       rs2_used_Q101H;
  logic [4:0] rd_Q101H;
  logic       reg_write_en_Q101H;
  logic       mem_rd_Q101H;
  logic       mem_acc_Q101H;
  logic       branch_taken_Q102H;
  logic       dmem_ready;
  logic       stall_Q100H;
  logic       stall_Q101H;
  logic       stall_Q102H;
  logic       stall_Q103H;
  logic       flush_Q101H;
  logic       flush_Q102H;
  t_fwd_sel   fwd_sel_rs1_Q102H;
  t_fwd_sel   fwd_sel_rs2_Q102H;
  logic [4:0] rd_Q103H;
  logic [4:0] rd_Q104H;
  logic       reg_write_en_Q103H;
  logic       reg_write_en_Q104H;
  logic       valid_Q102H;
  logic       valid_Q103H;
  logic       valid_Q104H;
  logic       mem_timeout;

  int total;
  int bad;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .inst_valid_Q101H   (inst_valid_Q101H),
    .rs1_Q101H          (rs1_Q101H),
    .rs2_Q101H          (rs2_Q101H),
    .rs1_used_Q101H     (rs1_used_Q101H),
    .rs2_used_Q101H     (rs2_used_Q101H),
    .rd_Q101H           (rd_Q101H),
    .reg_write_en_Q101H (reg_write_en_Q101H),
    .mem_rd_Q101H       (mem_rd_Q101H),
    .mem_acc_Q101H      (mem_acc_Q101H),
    .branch_taken_Q102H (branch_taken_Q102H),
    .dmem_ready         (dmem_ready),
    .stall_Q100H        (stall_Q100H),
    .stall_Q101H        (stall_Q101H),
    .stall_Q102H        (stall_Q102H),
    .stall_Q103H        (stall_Q103H),
    .flush_Q101H        (flush_Q101H),
    .flush_Q102H        (flush_Q102H),
    .fwd_sel_rs1_Q102H  (fwd_sel_rs1_Q102H),
    .fwd_sel_rs2_Q102H  (fwd_sel_rs2_Q102H),
    .rd_Q103H           (rd_Q103H),
    .rd_Q104H           (rd_Q104H),
    .reg_write_en_Q103H (reg_write_en_Q103H),
    .reg_write_en_Q104H (reg_write_en_Q104H),
    .valid_Q102H        (valid_Q102H),
    .valid_Q103H        (valid_Q103H),
    .valid_Q104H        (valid_Q104H),
    .mem_timeout        (mem_timeout)
  );

  // 10 ns core clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packs the six sequencing strobes into one comparable value
  function automatic logic [7:0] hzVec();
    return {2'b00, stall_Q100H, stall_Q101H, stall_Q102H, stall_Q103H,
            flush_Q101H, flush_Q102H};
  endfunction

  // Drives the decode-stage instruction and lets combinational logic settle
  task automatic applyStimulus(input logic v, input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2,
                               input logic [4:0] rd, input logic we,
                               input logic mrd, input logic macc);
    inst_valid_Q101H   = v;
    rs1_Q101H          = r1;
    rs1_used_Q101H     = u1;
    rs2_Q101H          = r2;
    rs2_used_Q101H     = u2;
    rd_Q101H           = rd;
    reg_write_en_Q101H = we;
    mem_rd_Q101H       = mrd;
    mem_acc_Q101H      = macc;
    #1;
  endtask

  // One comparison: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advance to the next falling edge (one rising edge passes)
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    branch_taken_Q102H = 1'b0;
    dmem_ready = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    #1;
    $display("[TB] reset state");
    checkOutput("rst_hz", hzVec(), HZ_NONE);
    checkOutput("rst_valids", {5'b0, valid_Q102H, valid_Q103H, valid_Q104H}, 8'h00);
    checkOutput("rst_rd", {rd_Q103H[3:0], rd_Q104H[3:0]}, 8'h00);
    checkOutput("rst_fwd", {4'b0, fwd_sel_rs1_Q102H, fwd_sel_rs2_Q102H}, 8'h00);
    checkOutput("rst_timeout", {7'b0, mem_timeout}, 8'h00);
    tick();
    rst_n = 1'b1;

    // lw x5 then dependent add x6,x5,x1
    $display("[TB] load-use");
    applyStimulus(1, 5'd2, 1, 5'd0, 0, 5'd5, 1, 1, 1);
    checkOutput("lw_first_hz", hzVec(), HZ_NONE);
    tick();
    applyStimulus(1, 5'd5, 1, 5'd1, 1, 5'd6, 1, 0, 0);
    checkOutput("lduse_hz", hzVec(), HZ_LDUSE);
    tick();
    #1;
    checkOutput("lduse_release_hz", hzVec(), HZ_NONE);
    checkOutput("lduse_bubble_q102", {7'b0, valid_Q102H}, 8'h00);
    checkOutput("lw_in_q103", {2'b0, valid_Q103H, rd_Q103H}, {2'b0, 1'b1, 5'd5});
    tick();
    // add x3,x1,x2 enters decode; add x6 now in execute
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0);
    checkOutput("lduse_fwd_rs1", 8'(fwd_sel_rs1_Q102H), 8'(FWD_Q104H));
    checkOutput("lduse_fwd_rs2", 8'(fwd_sel_rs2_Q102H), 8'(FWD_NONE));
    checkOutput("lw_in_q104", {2'b0, reg_write_en_Q104H, rd_Q104H}, {2'b0, 1'b1, 5'd5});
    tick();

    // add x3 twice, then sub x4,x3,x3
    $display("[TB] forwarding priority");
    applyStimulus(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0);
    checkOutput("add3_fwd", {4'b0, fwd_sel_rs1_Q102H, fwd_sel_rs2_Q102H}, 8'h00);
    tick();
    applyStimulus(1, 5'd3, 1, 5'd3, 1, 5'd4, 1, 0, 0);
    tick();
    // addi x0 into decode; sub in execute with x3 in both Q103H and Q104H
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0);
    checkOutput("both_q103_rs1", 8'(fwd_sel_rs1_Q102H), 8'(FWD_Q103H));
    checkOutput("both_q103_rs2", 8'(fwd_sel_rs2_Q102H), 8'(FWD_Q103H));
    checkOutput("dup_rd_q104", {3'b0, rd_Q104H}, 8'd3);
    tick();
    applyStimulus(1, 5'd0, 1, 5'd0, 1, 5'd8, 1, 0, 0);
    tick();
    // add x8,x0,x0 in execute, x0 writer in Q103H
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("x0_fwd", {4'b0, fwd_sel_rs1_Q102H, fwd_sel_rs2_Q102H}, 8'h00);
    tick();

    // lw x9 in execute that resolves taken, dependent add in decode
    $display("[TB] branch over load-use");
    applyStimulus(1, 5'd2, 1, 5'd0, 0, 5'd9, 1, 1, 1);
    tick();
    branch_taken_Q102H = 1'b1;
    applyStimulus(1, 5'd9, 1, 5'd9, 1, 5'd10, 1, 0, 0);
    checkOutput("branch_hz", hzVec(), HZ_BRANCH);
    tick();
    branch_taken_Q102H = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("branch_flushed_q102", {7'b0, valid_Q102H}, 8'h00);
    checkOutput("branch_in_q103", {7'b0, valid_Q103H}, 8'h01);
    tick();

    // store stalled 3 cycles in Q103H
    $display("[TB] memory wait");
    applyStimulus(1, 5'd2, 1, 5'd3, 1, 5'd0, 0, 0, 1);
    tick();
    applyStimulus(1, 5'd1, 1, 5'd1, 1, 5'd11, 1, 0, 0);
    tick();
    dmem_ready = 1'b0;
    applyStimulus(1, 5'd1, 1, 5'd0, 0, 5'd12, 1, 0, 0);
    checkOutput("wait1_hz", hzVec(), HZ_FREEZE);
    tick();
    #1;
    checkOutput("wait2_hz", hzVec(), HZ_FREEZE);
    checkOutput("wait_state", 8'(dut.state), 8'(MEM_WAIT));
    checkOutput("wait_bubble1", {7'b0, valid_Q104H}, 8'h00);
    tick();
    #1;
    checkOutput("wait3_hz", hzVec(), HZ_FREEZE);
    checkOutput("wait_bubble2", {7'b0, valid_Q104H}, 8'h00);
    tick();
    dmem_ready = 1'b1;
    #1;
    checkOutput("wait_release_hz", hzVec(), HZ_NONE);
    checkOutput("wait_bubble3", {7'b0, valid_Q104H}, 8'h00);
    checkOutput("short_wait_no_timeout", {7'b0, mem_timeout}, 8'h00);
    tick();
    #1;
    checkOutput("store_in_q104", {6'b0, valid_Q104H, reg_write_en_Q104H}, 8'h02);
    checkOutput("add11_in_q103", {2'b0, valid_Q103H, rd_Q103H}, {2'b0, 1'b1, 5'd11});
    checkOutput("run_state", 8'(dut.state), 8'(RUN));

    // lw x13 held waiting for 6 cycles
    $display("[TB] memory timeout");
    applyStimulus(1, 5'd2, 1, 5'd0, 0, 5'd13, 1, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    dmem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      checkOutput($sformatf("to_stall_%0d", i), {7'b0, stall_Q103H}, 8'h01);
      checkOutput($sformatf("to_flag_%0d", i), {7'b0, mem_timeout}, {7'b0, (i >= 4)});
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    checkOutput("to_release_hz", hzVec(), HZ_NONE);
    tick();
    #1;
    checkOutput("to_sticky", {7'b0, mem_timeout}, 8'h01);
    checkOutput("lw13_in_q104", {2'b0, valid_Q104H, rd_Q104H}, {2'b0, 1'b1, 5'd13});

    // reset asserted mid-wait
    $display("[TB] reset during wait");
    applyStimulus(1, 5'd2, 1, 5'd3, 1, 5'd0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    dmem_ready = 1'b0;
    #1;
    checkOutput("pre_rst_hz", hzVec(), HZ_FREEZE);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_hz", hzVec(), HZ_NONE);
    checkOutput("midrst_valids", {5'b0, valid_Q102H, valid_Q103H, valid_Q104H}, 8'h00);
    checkOutput("midrst_we", {6'b0, reg_write_en_Q103H, reg_write_en_Q104H}, 8'h00);
    checkOutput("midrst_timeout", {7'b0, mem_timeout}, 8'h00);
    checkOutput("midrst_state", 8'(dut.state), 8'(RUN));
    tick();
    rst_n = 1'b1;
    dmem_ready = 1'b1;
    applyStimulus(1, 5'd1, 1, 5'd1, 1, 5'd14, 1, 0, 0);
    checkOutput("post_rst_hz", hzVec(), HZ_NONE);
    tick();
    applyStimulus(1, 5'd14, 1, 5'd0, 0, 5'd15, 1, 0, 0);
    checkOutput("post_rst_valid_q102", {7'b0, valid_Q102H}, 8'h01);
    tick();
    #1;
    checkOutput("post_rst_fwd", 8'(fwd_sel_rs1_Q102H), 8'(FWD_Q103H));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
